// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared constants for the intersection controller front-end: sensor bit
// indices on the controller's sensors[4:0] bus and the default mask that
// selects latched call channels versus level presence channels.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int SENSOR_COUNT = 5;

    // Bit positions on the sensors bus.
    localparam int SENS_LEFT_MAIN     = 0;
    localparam int SENS_LEFT_CROSS    = 1;
    localparam int SENS_TRAFFIC_CROSS = 2;
    localparam int SENS_WALK_MAIN     = 3;
    localparam int SENS_WALK_CROSS    = 4;

    typedef logic [SENSOR_COUNT-1:0] sensor_vec_t;

    // 1 = latched call (button), 0 = level presence (loop detector).
    // Only the cross-traffic loop is a level channel.
    localparam sensor_vec_t DEFAULT_LATCH_MASK = sensor_vec_t'(
        (1 << SENS_LEFT_MAIN)  | (1 << SENS_LEFT_CROSS) |
        (1 << SENS_WALK_MAIN)  | (1 << SENS_WALK_CROSS));

endpackage : traffic_pkg

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One sensor channel: two-flop synchronizer, stability counter, debounced
// level flop and a one-cycle pulse on each accepted rising transition.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   raw_i         unsynchronized raw input
//   stable_o      debounced level (registered)
//   stable_next_o value stable_o takes at the coming edge (lets the parent
//                 register derived state on the same edge)
//   press_pulse_o one-cycle pulse on each debounced 0->1 transition
// -----------------------------------------------------------------------------
module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic stable_next_o,
    output logic press_pulse_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any return to agreement restarts it, so glitches shorter
    // than DEBOUNCE_CYCLES never reach stable_q and cnt never passes CNT_LAST.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = stable_d & ~stable_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign stable_o      = stable_q;
    assign stable_next_o = stable_d;
    assign press_pulse_o = press_q;

endmodule : debounce_chan

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
// Conditions raw push-button and loop-sensor inputs into clean requests for
// the intersection controller. Every channel is synchronized and debounced;
// call channels hold their request until the controller acknowledges service,
// presence channels follow the debounced level.
//
// Ports
//   clk          system clock (50 MHz)
//   reset        synchronous, active-high reset
//   raw_sensors  unsynchronized button/loop inputs, active-high
//   clear        per-channel service acknowledge, one-cycle pulse
//   sensors      conditioned requests (bit map in traffic_pkg)
//   stable       debounced level per channel
//   press_pulse  one-cycle pulse on each debounced 0->1 transition
// -----------------------------------------------------------------------------
module sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int          N               = SENSOR_COUNT,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 19,
    parameter logic [N-1:0] LATCH_MASK     = DEFAULT_LATCH_MASK
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] raw_sensors,
    input  logic [N-1:0] clear,
    output logic [N-1:0] sensors,
    output logic [N-1:0] stable,
    output logic [N-1:0] press_pulse
);

    logic [N-1:0] stable_next;
    logic [N-1:0] rise;
    logic [N-1:0] sensors_q;
    logic [N-1:0] sensors_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce_chan (
            .clk           (clk),
            .reset         (reset),
            .raw_i         (raw_sensors[gi]),
            .stable_o      (stable[gi]),
            .stable_next_o (stable_next[gi]),
            .press_pulse_o (press_pulse[gi])
        );
    end

    // Rising debounced edge happening at the coming clock edge.
    assign rise = stable_next & ~stable;

    // Latched channels: a set event wins over a simultaneous clear, and only a
    // fresh rising edge sets, so a button held across its clear stays cleared.
    // Level channels register the next debounced level, which keeps them
    // cycle-aligned with stable and ignores clear.
    always_comb begin
        sensors_d = ((rise | (sensors_q & ~clear)) &  LATCH_MASK)
                  | (stable_next                   & ~LATCH_MASK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sensors_q <= '0;
        end else begin
            sensors_q <= sensors_d;
        end
    end

    assign sensors = sensors_q;

endmodule : sensor_conditioner
